// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned STARVE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data completions seen while fetch waits; force_i
// flips arbitration to fetch once the limit is reached.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rd,
  input  logic i_cpl,
  input  logic d_cpl,
  output logic force_i
);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!i_rd || i_cpl) begin
      cnt <= '0;
    end else if (d_cpl && (cnt != '1)) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign force_i = (32'(cnt) >= STARVE_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a stalling single-port memory between fetch and data ports.
// Define ARB_STATS_EN to add completion/stall statistics counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
`ifdef ARB_STATS_EN
  ,parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_err,
  output logic              busy
`ifdef ARB_STATS_EN
  ,output logic [CNT_W-1:0] stat_i_cnt
  ,output logic [CNT_W-1:0] stat_d_cnt
  ,output logic [CNT_W-1:0] stat_stall_cnt
`endif
);

  arb_state_t state;
  owner_t     winner;
  mem_req_t   req;
  logic       force_i;
  logic       req_d;
  logic       illegal;
  logic       sel_i;
  logic       sel_d;
  logic       strobe;

  assign req_d   = d_rd | d_wr;
  assign illegal = d_rd & d_wr;
  assign strobe  = req.rd | req.wr;

  // Port selection: live arbitration in IDLE, locked owner otherwise.
  always_comb begin
    winner = OWNER_D;
    sel_i  = 1'b0;
    sel_d  = 1'b0;
    if (i_rd && (!req_d || force_i)) winner = OWNER_I;
    if (!rst) begin
      case (state)
        IDLE: begin
          sel_i = i_rd && (winner == OWNER_I);
          sel_d = req_d && (winner == OWNER_D);
        end
        OWN_I:   sel_i = i_rd;
        OWN_D:   sel_d = req_d;
        default: ;
      endcase
    end
  end

  // Memory request and completion routing; illegal data requests never reach memory.
  always_comb begin
    req       = '0;
    req.rd    = sel_i | (sel_d & d_rd & ~d_wr);
    req.wr    = sel_d & d_wr & ~d_rd;
    if (req.rd || req.wr) req.addr = sel_i ? i_addr : d_addr;
    if (sel_d) req.wdata = d_wdata;
    i_done  = sel_i & mem_done;
    i_rdata = i_done ? mem_rdata : '0;
    i_err   = i_done & mem_err;
    d_done  = sel_d & (illegal | mem_done);
    d_err   = sel_d & (illegal | (mem_done & mem_err));
    d_rdata = (sel_d & ~illegal & mem_done & d_rd) ? mem_rdata : '0;
  end

  assign mem_rd    = req.rd;
  assign mem_wr    = req.wr;
  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe && mem_stall && !mem_done) begin
            state <= sel_i ? OWN_I : OWN_D;
            busy  <= 1'b1;
          end
        end
        OWN_I: begin
          if (!sel_i || mem_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        OWN_D: begin
          if (!sel_d || illegal || mem_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_rd    (i_rd),
    .i_cpl   (i_done),
    .d_cpl   (d_done),
    .force_i (force_i)
  );

`ifdef ARB_STATS_EN
  // Wrapping event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_i_cnt     <= '0;
      stat_d_cnt     <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (i_done) stat_i_cnt <= stat_i_cnt + CNT_W'(1);
      if (d_done) stat_d_cnt <= stat_d_cnt + CNT_W'(1);
      if (strobe && mem_stall) stat_stall_cnt <= stat_stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a stalling memory
// model and a transaction-level scoreboard.
module tb_mem_arbiter;

  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_done, i_err, d_done, d_err, busy;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_i_cnt, stat_d_cnt, stat_stall_cnt;
  int          m_icnt, m_dcnt, m_scnt;
`endif

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err),
    .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_i_cnt(stat_i_cnt), .stat_d_cnt(stat_d_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int a);
    if (a == 16) return 16'hBEEF;
    return 16'(a * 40503 + 7);
  endfunction

  // Memory model: programmable stall count per access, odd address -> error.
  logic [15:0] mem [0:255];
  logic        mem_init = 1'b0;
  int          wr_events = 0;
  int          stall_mode = 0;
  int          stall_left = 0;

  assign mem_done  = (mem_rd | mem_wr) && (stall_left == 0);
  assign mem_stall = (mem_rd | mem_wr) && (stall_left != 0);
  assign mem_err   = (mem_rd | mem_wr) && mem_addr[0];
  assign mem_rdata = mem_rd ? mem[mem_addr[7:0]] : 16'h0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
      mem_init <= 1'b1;
    end else if (mem_wr && mem_done) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_events <= wr_events + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst)            stall_left <= (stall_mode < 0) ? 0 : stall_mode;
    else if (mem_stall) stall_left <= stall_left - 1;
    else                stall_left <= (stall_mode < 0) ? int'($urandom_range(3)) : stall_mode;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [15:0] shadow [0:255];
  int          wr_expected = 0;

  // Random-phase agent state
  logic        i_pend, d_pend, p_idone, p_ddone;
  int          i_age, d_age, waits, kind;

  initial begin
    for (int a = 0; a < 256; a++) shadow[a] = init_word(a);

    // Reset with requests pending: everything stays quiet.
    i_rd = 1'b1; d_rd = 1'b1; d_addr = 16'h0020;
    repeat (2) @(negedge clk);
    #2;
    check("rst_i_done", {31'b0, i_done}, 0);
    check("rst_d_done", {31'b0, d_done}, 0);
    check("rst_strobe", {30'b0, mem_rd, mem_wr}, 0);
    check("rst_busy",   {31'b0, busy}, 0);
    i_rd = 1'b0; d_rd = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Fetch only, zero wait.
    @(negedge clk); i_rd = 1'b1; i_addr = 16'h0010;
    #2;
    check("f0_done",  {31'b0, i_done}, 1);
    check("f0_rdata", {16'b0, i_rdata}, 32'hBEEF);
    @(posedge clk); #1;
    check("f0_busy", {31'b0, busy}, 0);
    @(negedge clk); i_rd = 1'b0; stall_mode = 3;

    // Both request, data write stalled three cycles.
    @(negedge clk);
    i_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      check("st_mem_wr", {31'b0, mem_wr}, 1);
      check("st_addr",   {16'b0, mem_addr}, 32'h0020);
      check("st_wdata",  {16'b0, mem_wdata}, 32'h1234);
      check("st_busy",   {31'b0, busy}, (k != 0) ? 1 : 0);
      check("st_d_done", {31'b0, d_done}, (k == 3) ? 1 : 0);
      check("st_i_done", {31'b0, i_done}, 0);
    end
    shadow[8'h20] = 16'h1234; wr_expected++;
    stall_mode = 0;
    @(negedge clk); d_wr = 1'b0;
    #2;
    check("st_fetch_after", {31'b0, i_done}, 1);
    check("st_fetch_data",  {16'b0, i_rdata}, 32'hBEEF);
    @(negedge clk); i_rd = 1'b0;

    // Starvation: fetch forced after every fourth back-to-back data completion.
    @(negedge clk); i_rd = 1'b1; i_addr = 16'h0010; d_rd = 1'b1; d_addr = 16'h0040;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        d_addr = 16'(16'h0040 + 2 * c);
      end
      #2;
      check("sv_i_done", {31'b0, i_done}, (c == 4 || c == 9) ? 1 : 0);
      check("sv_d_done", {31'b0, d_done}, (c == 4 || c == 9) ? 0 : 1);
      if (d_done) check("sv_d_rdata", {16'b0, d_rdata}, {16'b0, shadow[d_addr[7:0]]});
    end
    @(negedge clk); i_rd = 1'b0; d_rd = 1'b0;

    // Illegal data request.
    @(negedge clk); d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0030;
    #2;
    check("il_strobe", {30'b0, mem_rd, mem_wr}, 0);
    check("il_done",   {31'b0, d_done}, 1);
    check("il_err",    {31'b0, d_err}, 1);
    @(negedge clk); d_rd = 1'b0; d_wr = 1'b0;

    // Odd address read error.
    @(negedge clk); d_rd = 1'b1; d_addr = 16'h0003;
    #2;
    check("odd_done",  {31'b0, d_done}, 1);
    check("odd_err",   {31'b0, d_err}, 1);
    check("odd_rdata", {16'b0, d_rdata}, {16'b0, shadow[3]});
    @(negedge clk); d_rd = 1'b0; stall_mode = 5;

    // Reset in the middle of a stalled write.
    @(negedge clk); d_wr = 1'b1; d_addr = 16'h0060; d_wdata = 16'hA5A5;
    @(posedge clk); #1;
    check("rm_busy_pre", {31'b0, busy}, 1);
    #2; rst = 1'b1;
    #1;
    check("rm_busy",   {31'b0, busy}, 0);
    check("rm_strobe", {30'b0, mem_rd, mem_wr}, 0);
    d_wr = 1'b0; stall_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef ARB_STATS_EN
    #1;
    check("rm_stat_i", {16'b0, stat_i_cnt}, 0);
    check("rm_stat_d", {16'b0, stat_d_cnt}, 0);
    check("rm_stat_s", {16'b0, stat_stall_cnt}, 0);
`endif
    @(negedge clk); d_wr = 1'b1;
    #2;
    check("rm_reissue", {31'b0, d_done}, 1);
    shadow[8'h60] = 16'hA5A5; wr_expected++;
    @(negedge clk); d_wr = 1'b0;

    // Randomized traffic against the scoreboard.
    rst = 1'b1; stall_mode = -1;
    @(negedge clk); rst = 1'b0;
`ifdef ARB_STATS_EN
    m_icnt = 0; m_dcnt = 0; m_scnt = 0;
`endif
    i_pend = 1'b0; d_pend = 1'b0; p_idone = 1'b0; p_ddone = 1'b0;
    i_age = 0; d_age = 0; waits = 0; kind = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (p_idone) i_pend = 1'b0;
      if (p_ddone) d_pend = 1'b0;
      if (!i_pend && $urandom_range(99) < 40) begin
        i_pend = 1'b1; i_age = 0; i_addr = 16'($urandom_range(255));
      end
      if (!d_pend && $urandom_range(99) < 50) begin
        d_pend = 1'b1; d_age = 0; kind = int'($urandom_range(99));
        d_addr = 16'($urandom_range(255)); d_wdata = 16'($urandom);
      end
      i_rd = i_pend;
      d_rd = d_pend && (kind < 50 || kind < 5);
      d_wr = d_pend && (kind >= 50 || kind < 5);
      #2;
      check("r_one_done", {31'b0, i_done & d_done}, 0);
      check("r_one_strobe", {31'b0, mem_rd & mem_wr}, 0);
      if (!(mem_rd | mem_wr)) check("r_addr_idle", {16'b0, mem_addr}, 0);
      if (mem_wr) begin
        check("r_wr_addr",  {16'b0, mem_addr}, {16'b0, d_addr});
        check("r_wr_wdata", {16'b0, mem_wdata}, {16'b0, d_wdata});
      end
      if (i_done) begin
        check("r_i_req",   {31'b0, i_pend}, 1);
        check("r_i_rdata", {16'b0, i_rdata}, {16'b0, shadow[i_addr[7:0]]});
        check("r_i_err",   {31'b0, i_err}, {31'b0, i_addr[0]});
      end
      if (d_done) begin
        check("r_d_req", {31'b0, d_pend}, 1);
        if (i_rd) begin
          check("r_starve", (waits < int'(SMAX)) ? 1 : 0, 1);
          waits++;
        end
        if (kind < 5) begin
          check("r_il_err",   {31'b0, d_err}, 1);
          check("r_il_rdata", {16'b0, d_rdata}, 0);
        end else begin
          check("r_d_err", {31'b0, d_err}, {31'b0, d_addr[0]});
          if (kind < 50) begin
            check("r_d_rdata", {16'b0, d_rdata}, {16'b0, shadow[d_addr[7:0]]});
          end else begin
            check("r_w_rdata", {16'b0, d_rdata}, 0);
            shadow[d_addr[7:0]] = d_wdata;
            wr_expected++;
          end
        end
      end
      if (i_done || !i_rd) waits = 0;
`ifdef ARB_STATS_EN
      if (i_done) m_icnt++;
      if (d_done) m_dcnt++;
      if ((mem_rd | mem_wr) && mem_stall) m_scnt++;
`endif
      p_idone = i_done; p_ddone = d_done;
      i_age++; d_age++;
      if (i_pend && !i_done && i_age > 40) begin
        check("r_i_timeout", i_age, 0); i_pend = 1'b0;
      end
      if (d_pend && !d_done && d_age > 40) begin
        check("r_d_timeout", d_age, 0); d_pend = 1'b0;
      end
    end
    @(negedge clk); i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("write_count", wr_events, wr_expected);
    begin
      int diffs = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== shadow[a]) diffs++;
      check("mem_contents", diffs, 0);
    end
`ifdef ARB_STATS_EN
    check("stat_i", {16'b0, stat_i_cnt}, 32'(m_icnt));
    check("stat_d", {16'b0, stat_d_cnt}, 32'(m_dcnt));
    check("stat_s", {16'b0, stat_stall_cnt}, 32'(m_scnt));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one stalling single-port 16-bit memory between the instruction-fetch port (read-only) and the data port (read/write).
- The memory completes an access combinationally in any cycle it is ready; otherwise it asserts stall, and the access must be retried unchanged.
- The arbiter selects an owner, locks that owner until the memory reports done, and routes done/data/err back.
- It sits between the fetch/memory stages and the memory model.

Parameters:
- STARVE_MAX, 4: consecutive data-port completions allowed while the fetch port is waiting, before fetch is forced to win.
- CNT_W, 16: width of the optional statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_rd  in  1  fetch read request; held until i_done
- i_addr  in  16  fetch address
- i_done  out  1  fetch access complete this cycle
- i_rdata  out  16  fetch read data; valid when i_done, else 0
- i_err  out  1  fetch error; pulses with i_done
- d_rd  in  1  data read request; held until d_done
- d_wr  in  1  data write request; held until d_done
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_done  out  1  data access complete this cycle
- d_rdata  out  16  data read data; valid when d_done and read, else 0
- d_err  out  1  data error; pulses with d_done
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_done  in  1  memory ready/complete
- mem_stall  in  1  memory stalled
- mem_err  in  1  memory error (odd address)
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, OWN_I, OWN_D (2-bit register). Reset sets state=IDLE, starve_cnt=0, last_owner=D. All outputs are 0 in reset and whenever no request is pending.
- IDLE arbitration is combinational, in the same cycle:
  - Only one port requesting: that port wins.
  - Both ports requesting: data wins unless starve_cnt >= STARVE_MAX, in which case fetch wins.
  - The winner's request is driven onto mem_* in that same cycle.
- Owner states: the owner's request is driven to memory every cycle. The other port is ignored, and its done/err stay 0.
- Transitions:
  - IDLE, mem_done=1: zero-wait completion; stay IDLE.
  - IDLE, mem_stall=1: go to OWN_I or OWN_D per the winner.
  - OWN_x, mem_done=1: go to IDLE.
  - OWN_x, otherwise: stay in OWN_x.
- Completion: x_done=mem_done for the owner; x_rdata=mem_rdata if read, else 0; x_err=mem_err.
- Illegal data request (d_rd & d_wr both 1):
  - Never forwarded to memory (mem_rd=mem_wr=0).
  - If the data port wins, d_done=1 and d_err=1 in the same cycle; state stays IDLE.
- Requester drops its request while owning (protocol violation): mem strobes go to 0 and state returns to IDLE next cycle. No done is issued.
- starve_cnt (3 bits, saturating):
  - +1 on each data completion while i_rd is high.
  - Cleared on any fetch completion, and whenever i_rd is low.
- mem_wdata = d_wdata when the data port owns the memory, else 0. mem_addr = 0 when no strobe is asserted.
- Reset asserted mid-access: immediate return to IDLE and all strobes drop asynchronously. The pending access is lost; requesters reissue it.
- A write occurs at most once: the memory writes only when mem_done is high, and the arbiter never re-presents a completed access.

Optional Feature:
- ARB_STATS_EN defined: adds output ports stat_i_cnt, stat_d_cnt, stat_stall_cnt (each CNT_W bits, wrapping):
  - stat_i_cnt counts fetch completions.
  - stat_d_cnt counts data completions, including illegal ones.
  - stat_stall_cnt counts cycles with a mem strobe and mem_stall=1.
  - All three are cleared by rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE=0, OWN_I=1, OWN_D=2);
  - owner encoding (OWNER_I, OWNER_D);
  - the ADDR_W=16 and DATA_W=16 constants.
- One natural sub-module, arb_starve_ctr: the saturating starvation counter with a force_i output.
- The statistics counters stay inline under the macro.

Test Plan:
- Fetch only, memory ready: i_rd=1, i_addr=0x0010, mem_done=1, mem_rdata=0xBEEF -> same cycle i_done=1, i_rdata=0xBEEF, state stays IDLE.
- Both ports request, memory stalls 3 cycles: data wins, d_wr=1, d_addr=0x0020, d_wdata=0x1234. mem_wr=1 is held 4 cycles, with busy=1 for 3 cycles. d_done pulses once on the 4th cycle, and i_done=0 throughout.
- Starvation: i_rd held, data issues 5 back-to-back reads with mem_done=1 -> fetch granted after the 4th data completion. i_done precedes the 5th d_done, and starve_cnt then clears to 0.
- Illegal request: d_rd=d_wr=1 -> mem_rd=mem_wr=0, and d_done=d_err=1 in the same cycle.
- Odd address: d_rd=1, d_addr=0x0003, mem_err=1, mem_done=1 -> d_done=1, d_err=1 forwarded.
- Reset mid-stall: rst pulsed while in OWN_D -> busy=0 and mem strobes=0 without waiting for clk; after release, the reissued request completes normally (with ARB_STATS_EN, counters read 0).
